tt_um_leg_solver: RTL
=====================

TT_UM_LEG_SOLVER -- requirements
Module: tt_um_leg_solver

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 ena  input  1  global enable; when 0, all internal state and outputs SHALL hold.
REQ-005 ui_in  input  8  operand data bus, unsigned.
REQ-006 uio_in  input  8  control inputs: bit0 load_c, bit1 load_a, bit2 start; bits 7:3 are ignored.
REQ-007 uo_out  output  8  result b = floor(sqrt(c*c - a*a)), registered.
REQ-008 uio_out  output  8  status outputs: bit3 busy, bit4 done, bit5 err; all other bits SHALL be 0.
REQ-009 uio_oe  output  8  SHALL be the constant 8'b0011_1000.

Function
REQ-010 Registers c_reg[7:0] and a_reg[7:0] SHALL capture ui_in on an enabled edge when load_c or load_a (respectively) is 1 and the FSM is in IDLE or DONE; both SHALL capture if both strobes are 1.
REQ-011 Load strobes SHALL be ignored while busy=1.
REQ-012 FSM states SHALL be IDLE, SQ_C, SQ_A, SUB, ROOT and DONE.
REQ-013 IDLE or DONE -> SQ_C on an enabled edge with start=1; working copies SHALL take the c_reg/a_reg values held before that edge; done and err SHALL clear on the same edge.
REQ-014 SQ_C SHALL compute c*c by shift-add over exactly 8 cycles, one multiplier bit per cycle, into a 16-bit accumulator; then -> SQ_A.
REQ-015 SQ_A SHALL compute a*a identically over exactly 8 cycles; then -> SUB.
REQ-016 SUB (1 cycle): D = c*c - a*a (16-bit); if a*a > c*c, D SHALL be forced to 0 and err SHALL be set; then -> ROOT.
REQ-017 ROOT SHALL compute floor(sqrt(D)) by an 8-iteration restoring digit-by-digit method, one result bit per cycle MSB first, without a hardware multiplier; then -> DONE.
REQ-018 Latency: for start sampled at edge k, busy SHALL be 1 after edges k+1..k+25, and uo_out (new result) and done=1 SHALL appear after edge k+26 with busy=0.
REQ-019 Latency SHALL be fixed at 26 cycles regardless of operand values or err.
REQ-020 uo_out SHALL change only on entry to DONE and SHALL hold its value through subsequent operations until the next DONE.
REQ-021 done and err SHALL remain set in DONE until the next accepted start or reset.
REQ-022 start held continuously high SHALL retrigger on the first enabled edge in DONE.
REQ-023 start asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-024 When ena=0, the FSM, its counters, accumulators and the load registers SHALL freeze; total latency SHALL extend by exactly the number of disabled cycles.
REQ-025 All arithmetic SHALL be unsigned; no intermediate value SHALL exceed 16 bits (255*255 = 65025 fits).

Reset
REQ-026 While rst_n=0, the following SHALL hold regardless of clk or ena: uo_out=0, c_reg=0, a_reg=0, busy=0, done=0, err=0, FSM=IDLE, all counters and accumulators 0.
REQ-027 A reset asserted mid-operation SHALL abort the operation immediately, with no partial result reaching uo_out.
REQ-028 After rst_n rises, the first start SHALL compute with c=a=0, giving uo_out=0 and err=0.

Verification
REQ-029 load_c with ui_in=5, load_a with ui_in=3, then start -> busy for 25 cycles, then uo_out=4, done=1, err=0.
REQ-030 c=255, a=1 -> uo_out=254; c=255, a=0 -> uo_out=255; c=10, a=10 -> uo_out=0, err=0.
REQ-031 c=100, a=200 -> uo_out=0, err=1, done=1 at cycle 26; a following start with a=60 -> err clears at start, then uo_out=80.
REQ-032 Start with c=5, a=3; hold ena=0 for 7 cycles mid-ROOT -> done appears at cycle 33 with uo_out=4; load strobes during busy leave c_reg/a_reg unchanged.
REQ-033 Start, then pulse rst_n low at cycle 12 -> all outputs 0 immediately; a prior uo_out value SHALL be cleared and no done pulse SHALL appear.
REQ-034 Hold start=1 continuously with c=13, a=5 -> uo_out=12 with done at cycles 26, 53, 80, ...; start at cycle 10 during busy has no effect.

Source files
------------

// File: rtl/tt_um_leg_solver.sv
// tt_um_leg_solver: computes b = floor(sqrt(c*c - a*a)) for unsigned 8-bit c and a.
// c*c and a*a come from a shift-add multiplier (one bit per cycle). Their difference is
// clamped to 0 with err set if a > c. The root comes from a restoring digit-by-digit
// method (one bit per cycle). Latency is fixed at 26 cycles from the start edge.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   ena     - global enable; all state holds while low
//   ui_in   - operand data bus
//   uio_in  - bit0 load_c, bit1 load_a, bit2 start (bits 7:3 ignored)
//   uo_out  - registered result b
//   uio_out - bit3 busy, bit4 done, bit5 err, other bits 0
//   uio_oe  - constant 8'b0011_1000
module tt_um_leg_solver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {StIdle, StSqC, StSqA, StSub, StRoot, StDone} state_t;

    state_t      state;
    logic [7:0]  c_reg, a_reg;
    logic [7:0]  wc, wa;       // working copies taken at start
    logic [15:0] acc;          // multiplier accumulator; holds a*a going into SUB
    logic [15:0] csq;          // c*c, then D, then shifted radicand during ROOT
    logic [9:0]  rem;          // root remainder, always < 2*root+1
    logic [7:0]  root;
    logic [3:0]  cnt;
    logic        busy, done, err;

    logic        load_c, load_a, start, idle_like;
    logic [7:0]  mul_op;
    logic [15:0] term, acc_sum;
    logic [11:0] rem_sh, trial;
    logic        rem_ge;
    logic        unused;

    assign load_c    = uio_in[0];
    assign load_a    = uio_in[1];
    assign start     = uio_in[2];
    assign unused    = &{1'b0, uio_in[7:3]};
    assign idle_like = (state == StIdle) || (state == StDone);

    assign uio_out = {2'b00, err, done, busy, 3'b000};
    assign uio_oe  = 8'b0011_1000;

    always_comb begin
        mul_op  = (state == StSqC) ? wc : wa;
        term    = mul_op[cnt[2:0]] ? ({8'h00, mul_op} << cnt[2:0]) : 16'h0000;
        acc_sum = acc + term;
        // Bring down the next two radicand bits and try appending a 1 to the root.
        rem_sh  = {rem, csq[15:14]};
        trial   = {2'b00, root, 2'b01};
        rem_ge  = (rem_sh >= trial);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= StIdle;
            c_reg  <= 8'h00;
            a_reg  <= 8'h00;
            wc     <= 8'h00;
            wa     <= 8'h00;
            acc    <= 16'h0000;
            csq    <= 16'h0000;
            rem    <= 10'h000;
            root   <= 8'h00;
            cnt    <= 4'h0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            uo_out <= 8'h00;
        end else if (ena) begin
            if (idle_like) begin
                if (load_c) c_reg <= ui_in;
                if (load_a) a_reg <= ui_in;
            end
            unique case (state)
                StIdle, StDone: begin
                    busy <= 1'b0;
                    if (start) begin
                        wc    <= c_reg;
                        wa    <= a_reg;
                        acc   <= 16'h0000;
                        cnt   <= 4'h0;
                        done  <= 1'b0;
                        err   <= 1'b0;
                        state <= StSqC;
                    end
                end
                StSqC: begin
                    busy <= 1'b1;
                    if (cnt == 4'd7) begin
                        csq   <= acc_sum;
                        acc   <= 16'h0000;
                        cnt   <= 4'h0;
                        state <= StSqA;
                    end else begin
                        acc <= acc_sum;
                        cnt <= cnt + 4'd1;
                    end
                end
                StSqA: begin
                    busy <= 1'b1;
                    acc  <= acc_sum;
                    if (cnt == 4'd7) begin
                        cnt   <= 4'h0;
                        state <= StSub;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                StSub: begin
                    busy <= 1'b1;
                    if (acc > csq) begin
                        csq <= 16'h0000;
                        err <= 1'b1;
                    end else begin
                        csq <= csq - acc;
                    end
                    rem   <= 10'h000;
                    root  <= 8'h00;
                    cnt   <= 4'h0;
                    state <= StRoot;
                end
                StRoot: begin
                    // Eight iterations, then one commit cycle that publishes the
                    // result; the commit cycle is what makes the total 26 cycles.
                    if (cnt == 4'd8) begin
                        uo_out <= root;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        cnt    <= 4'h0;
                        state  <= StDone;
                    end else begin
                        busy <= 1'b1;
                        rem  <= 10'(rem_ge ? (rem_sh - trial) : rem_sh);
                        root <= {root[6:0], rem_ge};
                        csq  <= {csq[13:0], 2'b00};
                        cnt  <= cnt + 4'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
